// File: rtl/branch_pkg.sv
// Shared types and sizing for the branch update queue.
// Entry layout is {pc, target}; pointer width follows the default depth.
package branch_pkg;

    localparam int BQ_ADDRESS_LEN = 16;
    localparam int BQ_DEPTH       = 4;
    localparam int BQ_PTR_W       = $clog2(BQ_DEPTH);

    typedef struct packed {
        logic [BQ_ADDRESS_LEN-1:0] pc;
        logic [BQ_ADDRESS_LEN-1:0] target;
    } bq_entry_t;

    function automatic logic bq_depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/bq_entry.sv
// One queue slot: valid bit, PC and target, plus lookup/resolve PC comparators.
// Updates land on the rising edge; comparators are combinational and gated by valid.
module bq_entry
    import branch_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_new_i,
    input  bq_entry_t                 new_entry_i,
    input  logic                      wr_tgt_i,
    input  logic [BQ_ADDRESS_LEN-1:0] new_target_i,
    input  logic                      inval_i,
    input  logic [BQ_ADDRESS_LEN-1:0] lookup_pc_i,
    input  logic [BQ_ADDRESS_LEN-1:0] resolve_pc_i,
    output logic                      valid_o,
    output bq_entry_t                 entry_o,
    output logic                      lookup_match_o,
    output logic                      resolve_match_o
);

    logic      valid_q, valid_d;
    bq_entry_t entry_q, entry_d;

    // A fresh write wins over everything else; the top never aims two strobes
    // at one slot, so the ordering only matters for robustness.
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (wr_new_i) begin
            valid_d = 1'b1;
            entry_d = new_entry_i;
        end else if (wr_tgt_i) begin
            entry_d.target = new_target_i;
        end else if (inval_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o         = valid_q;
    assign entry_o         = entry_q;
    assign lookup_match_o  = valid_q && (entry_q.pc == lookup_pc_i);
    assign resolve_match_o = valid_q && (entry_q.pc == resolve_pc_i);

endmodule

// File: rtl/branch_update_queue.sv
// Coalescing FIFO of taken branches draining one per cycle into the BTB write port.
// Enqueue visible after the accepting edge; ready = !full, never raised by a same-cycle pop.
module branch_update_queue
    import branch_pkg::*;
#(
    parameter int DEPTH       = BQ_DEPTH,
    parameter int ADDRESS_LEN = BQ_ADDRESS_LEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    input  logic [ADDRESS_LEN-1:0]   resolve_pc,
    input  logic [ADDRESS_LEN-1:0]   resolve_target,
    output logic                     resolve_ready,
    input  logic                     btb_stall,
    output logic [ADDRESS_LEN-1:0]   pc_bits_write,
    output logic [ADDRESS_LEN-1:0]   target_address_in,
    output logic                     write_enabled,
    input  logic [ADDRESS_LEN-1:0]   lookup_pc,
    output logic                     lookup_hit,
    output logic [ADDRESS_LEN-1:0]   lookup_target,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage uses the package struct, so its width must agree.
    if (!bq_depth_ok(DEPTH)) begin : g_bad_depth
        $error("branch_update_queue: DEPTH must be a power of two >= 2");
    end
    if (ADDRESS_LEN != BQ_ADDRESS_LEN) begin : g_bad_width
        $error("branch_update_queue: ADDRESS_LEN must match branch_pkg");
    end

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] lookup_match;
    logic [DEPTH-1:0] resolve_match;
    logic [DEPTH-1:0] coal_sel;
    logic [DEPTH-1:0] wr_new;
    logic [DEPTH-1:0] wr_tgt;
    logic [DEPTH-1:0] inval;
    bq_entry_t        slots [DEPTH];
    bq_entry_t        new_entry;
    bq_entry_t        head_entry;

    logic pop;
    logic take;
    logic coalesce;
    logic enqueue;

    assign full          = (count_q == CNT_W'(DEPTH));
    assign resolve_ready = !full;
    assign write_enabled = (count_q != '0) && !btb_stall;
    assign pop           = write_enabled;
    assign take          = resolve_valid && resolve_ready && resolve_taken;
    assign new_entry     = '{pc: resolve_pc, target: resolve_target};

    // The head leaving this cycle cannot absorb an update: the BTB is already
    // capturing its old target, so a matching branch becomes a new entry.
    always_comb begin
        coal_sel = resolve_match;
        if (pop) begin
            coal_sel[head_q] = 1'b0;
        end
    end

    assign coalesce = take && (|coal_sel);
    assign enqueue  = take && !(|coal_sel);

    always_comb begin
        wr_new = '0;
        wr_tgt = '0;
        inval  = '0;
        if (enqueue) begin
            wr_new[tail_q] = 1'b1;
        end
        if (coalesce) begin
            wr_tgt = coal_sel;
        end
        if (pop) begin
            inval[head_q] = 1'b1;
        end
    end

    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(enqueue);
        count_d = count_q + CNT_W'(enqueue) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        bq_entry u_entry (
            .clk             (clk),
            .reset           (reset),
            .wr_new_i        (wr_new[g]),
            .new_entry_i     (new_entry),
            .wr_tgt_i        (wr_tgt[g]),
            .new_target_i    (resolve_target),
            .inval_i         (inval[g]),
            .lookup_pc_i     (lookup_pc),
            .resolve_pc_i    (resolve_pc),
            .valid_o         (slot_valid[g]),
            .entry_o         (slots[g]),
            .lookup_match_o  (lookup_match[g]),
            .resolve_match_o (resolve_match[g])
        );
    end

    assign head_entry        = slots[head_q];
    assign pc_bits_write     = slot_valid[head_q] ? head_entry.pc     : '0;
    assign target_address_in = slot_valid[head_q] ? head_entry.target : '0;

    // At most one valid slot holds a given PC, so an OR-reduce is a clean mux.
    always_comb begin
        lookup_hit    = 1'b0;
        lookup_target = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (lookup_match[i]) begin
                lookup_hit    = 1'b1;
                lookup_target = lookup_target | slots[i].target;
            end
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue with a queue-based reference model.
module tb_branch_update_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] tgt;
    } m_ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [15:0] resolve_pc;
    logic [15:0] resolve_target;
    logic        resolve_ready;
    logic        btb_stall;
    logic [15:0] pc_bits_write;
    logic [15:0] target_address_in;
    logic        write_enabled;
    logic [15:0] lookup_pc;
    logic        lookup_hit;
    logic [15:0] lookup_target;
    logic [2:0]  count;
    logic        full;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    m_ent_t      mq[$];
    logic [31:0] btb_log[$];

    always #5 clk = ~clk;

    branch_update_queue #(.DEPTH(DEPTH), .ADDRESS_LEN(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .resolve_valid     (resolve_valid),
        .resolve_taken     (resolve_taken),
        .resolve_pc        (resolve_pc),
        .resolve_target    (resolve_target),
        .resolve_ready     (resolve_ready),
        .btb_stall         (btb_stall),
        .pc_bits_write     (pc_bits_write),
        .target_address_in (target_address_in),
        .write_enabled     (write_enabled),
        .lookup_pc         (lookup_pc),
        .lookup_hit        (lookup_hit),
        .lookup_target     (lookup_target),
        .count             (count),
        .full              (full)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an ordered list of pending {pc,target}; compare then advance on each negedge.
    always @(negedge clk) begin
        int          sz;
        logic        e_we;
        logic        e_hit;
        logic [15:0] e_tgt;
        logic        m_pop;
        logic        m_take;
        logic        found;
        sz    = mq.size();
        e_we  = (sz != 0) && !btb_stall;
        e_hit = 1'b0;
        e_tgt = 16'h0;
        for (int j = 0; j < sz; j++) begin
            if (mq[j].pc == lookup_pc) begin
                e_hit = 1'b1;
                e_tgt = mq[j].tgt;
            end
        end
        if (chk_en) begin
            check("count", 32'(count), 32'(sz));
            check("full", 32'(full), 32'(sz == DEPTH));
            check("resolve_ready", 32'(resolve_ready), 32'(sz != DEPTH));
            check("write_enabled", 32'(write_enabled), 32'(e_we));
            check("pc_bits_write", 32'(pc_bits_write), 32'((sz != 0) ? mq[0].pc : 16'h0));
            check("target_address_in", 32'(target_address_in), 32'((sz != 0) ? mq[0].tgt : 16'h0));
            check("lookup_hit", 32'(lookup_hit), 32'(e_hit));
            check("lookup_target", 32'(lookup_target), 32'(e_tgt));
        end
        if (write_enabled === 1'b1) begin
            btb_log.push_back({pc_bits_write, target_address_in});
        end
        if (!reset) begin
            mq.delete();
        end else begin
            m_pop  = e_we;
            m_take = resolve_valid && (sz < DEPTH) && resolve_taken;
            found  = 1'b0;
            if (m_take) begin
                for (int j = 0; j < sz; j++) begin
                    if (!(m_pop && j == 0) && mq[j].pc == resolve_pc) begin
                        mq[j].tgt = resolve_target;
                        found     = 1'b1;
                    end
                end
            end
            if (m_pop) begin
                void'(mq.pop_front());
            end
            if (m_take && !found) begin
                mq.push_back('{pc: resolve_pc, tgt: resolve_target});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic taken, input logic [15:0] pc, input logic [15:0] tgt);
        resolve_valid  = 1'b1;
        resolve_taken  = taken;
        resolve_pc     = pc;
        resolve_target = tgt;
    endtask

    task automatic idle();
        resolve_valid  = 1'b0;
        resolve_taken  = 1'b0;
        resolve_pc     = 16'h0;
        resolve_target = 16'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        reset     = 1'b0;
        btb_stall = 1'b0;
        lookup_pc = 16'h0;
        idle();

        // Reset held for two edges
        tick();
        chk_en = 1;
        tick();
        check("lit_reset_count", 32'(count), 0);
        check("lit_reset_ready", 32'(resolve_ready), 1);
        check("lit_reset_we", 32'(write_enabled), 0);
        check("lit_reset_full", 32'(full), 0);
        check("lit_reset_pc", 32'(pc_bits_write), 0);
        check("lit_reset_hit", 32'(lookup_hit), 0);
        reset = 1'b1;

        // Not-taken branch is discarded
        send(1'b0, 16'h0040, 16'h0099);
        lookup_pc = 16'h0040;
        tick();
        idle();
        #1;
        check("lit_nt_count", 32'(count), 0);
        check("lit_nt_we", 32'(write_enabled), 0);
        check("lit_nt_ready", 32'(resolve_ready), 1);
        check("lit_nt_hit", 32'(lookup_hit), 0);

        // Single drain
        send(1'b1, 16'h0100, 16'h0200);
        tick();
        idle();
        lookup_pc = 16'h0100;
        #1;
        check("lit_drain_we", 32'(write_enabled), 1);
        check("lit_drain_pc", 32'(pc_bits_write), 'h0100);
        check("lit_drain_tgt", 32'(target_address_in), 'h0200);
        check("lit_drain_hit", 32'(lookup_hit), 1);
        tick();
        check("lit_drain_count", 32'(count), 0);

        // Fill to full under stall, then drain in order; three rounds wrap the pointers
        for (int r = 0; r < 3; r++) begin
            btb_stall = 1'b1;
            for (int k = 0; k < 4; k++) begin
                send(1'b1, 16'(16'h1000 + r * 16'h100 + k * 16'h10), 16'(16'h2000 + r * 16'h100 + k));
                tick();
            end
            send(1'b1, 16'h1F00, 16'h2F00);
            #1;
            check("lit_full_flag", 32'(full), 1);
            check("lit_full_ready", 32'(resolve_ready), 0);
            check("lit_full_count", 32'(count), 4);
            tick();
            idle();
            btb_stall = 1'b0;
            base = btb_log.size();
            for (int k = 0; k < 4; k++) tick();
            check("lit_wrap_nwrites", 32'(btb_log.size() - base), 4);
            for (int k = 0; k < 4 && base + k < btb_log.size(); k++) begin
                check("lit_wrap_order", btb_log[base + k],
                      {16'(16'h1000 + r * 16'h100 + k * 16'h10), 16'(16'h2000 + r * 16'h100 + k)});
            end
            check("lit_wrap_empty", 32'(count), 0);
        end

        // Coalesce into a stalled entry
        btb_stall = 1'b1;
        send(1'b1, 16'h0300, 16'h0400);
        tick();
        send(1'b1, 16'h0300, 16'h0500);
        tick();
        idle();
        lookup_pc = 16'h0300;
        #1;
        check("lit_coal_count", 32'(count), 1);
        check("lit_coal_hit", 32'(lookup_hit), 1);
        check("lit_coal_tgt", 32'(lookup_target), 'h0500);
        btb_stall = 1'b0;
        base = btb_log.size();
        tick();
        check("lit_coal_write", (btb_log.size() > base) ? btb_log[base] : 32'h0, 32'h03000500);

        // Same PC arrives while its entry is popping
        btb_stall = 1'b1;
        send(1'b1, 16'h0600, 16'h0700);
        tick();
        btb_stall = 1'b0;
        send(1'b1, 16'h0600, 16'h0800);
        lookup_pc = 16'h0600;
        #1;
        check("lit_excl_we", 32'(write_enabled), 1);
        check("lit_excl_pc", 32'(pc_bits_write), 'h0600);
        check("lit_excl_tgt", 32'(target_address_in), 'h0700);
        check("lit_excl_lookup", 32'(lookup_target), 'h0700);
        tick();
        idle();
        #1;
        check("lit_excl_count", 32'(count), 1);
        check("lit_excl_pc2", 32'(pc_bits_write), 'h0600);
        check("lit_excl_tgt2", 32'(target_address_in), 'h0800);
        tick();
        check("lit_excl_empty", 32'(count), 0);

        // Reset discards queued entries
        btb_stall = 1'b1;
        send(1'b1, 16'h0900, 16'h0901);
        tick();
        send(1'b1, 16'h0A00, 16'h0A01);
        tick();
        send(1'b1, 16'h0B00, 16'h0B01);
        tick();
        idle();
        #1;
        check("lit_rst_pre_count", 32'(count), 3);
        reset = 1'b0;
        base = btb_log.size();
        tick();
        reset = 1'b1;
        btb_stall = 1'b0;
        #1;
        check("lit_rst_count", 32'(count), 0);
        check("lit_rst_we", 32'(write_enabled), 0);
        for (int k = 0; k < 3; k++) begin
            lookup_pc = 16'(16'h0900 + k * 16'h0100);
            #1;
            check("lit_rst_lookup", 32'(lookup_hit), 0);
        end
        tick();
        check("lit_rst_nowrite", 32'(btb_log.size() - base), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_update_queue.md
# branch_update_queue

Buffers resolved taken branches from the execute stage and drains them, one per cycle, into the branch target buffer write port (`pc_bits_write`, `target_address_in`, `write_enabled`). It sits directly upstream of the BTB. It decouples branch resolution timing from BTB write availability, and coalesces repeated updates to the same PC. A combinational lookup port lets fetch see targets that are still queued and not yet written.

## Interface
- `DEPTH`, 4: queue entries; power of two, minimum 2.
- `ADDRESS_LEN`, 16: width of PC and target.
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-low reset.
- `resolve_valid` input 1: execute presents a resolved branch.
- `resolve_taken` input 1: branch was taken; not-taken branches are consumed and discarded.
- `resolve_pc` input ADDRESS_LEN: PC of the resolved branch.
- `resolve_target` input ADDRESS_LEN: resolved target address.
- `resolve_ready` output 1: queue accepts a branch this cycle; equals `!full`.
- `btb_stall` input 1: BTB write port unavailable this cycle.
- `pc_bits_write` output ADDRESS_LEN: head entry PC.
- `target_address_in` output ADDRESS_LEN: head entry target.
- `write_enabled` output 1: `count != 0 && !btb_stall`.
- `lookup_pc` input ADDRESS_LEN: fetch PC to check against queued entries.
- `lookup_hit` output 1: a valid queued entry has PC equal to `lookup_pc`.
- `lookup_target` output ADDRESS_LEN: target of the matching entry; 0 when no hit.
- `count` output log2(DEPTH)+1: number of occupied entries.
- `full` output 1: `count == DEPTH`.

## Operation
- Storage is a circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus one valid bit per entry.
- **Accept:** `accept = resolve_valid && resolve_ready`. An accepted branch with `resolve_taken == 0` changes no state.
- **Pop:** `pop = write_enabled`. The BTB captures the head entry on the same edge; the head is invalidated and the head pointer advances.
- **Coalesce:**
  - An accepted taken branch whose PC matches a valid entry overwrites that entry's target in place; count and tail are unchanged.
  - The head entry is excluded from matching in a cycle where `pop` is 1. In that case the branch is enqueued as a new entry, so the update is not lost.
  - By this rule at most one valid entry matches any PC.
- **Enqueue:** an accepted taken branch with no match is written at the tail; the tail pointer advances and count increments.
- **Simultaneous enqueue and pop:** count is unchanged and both pointers advance. This is legal at any occupancy below full.
- **Full:** `resolve_ready` is 0 and execute must hold its request. A same-cycle pop does not raise ready (no combinational path from `btb_stall` to `resolve_ready`).
- **Lookup:** combinational over all valid entries, including the head being popped this cycle. Lookup never alters state.
- **Outputs when empty:** `pc_bits_write` and `target_address_in` drive 0 and `write_enabled` is 0.

## Timing
- **Reset** (`reset == 0` at a rising edge):
  - Pointers, count and all valid bits clear to 0.
  - Output values: `full = 0`, `resolve_ready = 1`, `write_enabled = 0`, `lookup_hit = 0`, `lookup_target = 0`, `pc_bits_write = 0`, `target_address_in = 0`.
  - Reset asserted mid-operation discards all pending entries with no BTB write issued.
- **Latency:** a branch accepted at edge N is visible on `lookup_hit` after edge N. With `btb_stall` low and the queue empty, it appears on the BTB write outputs in cycle N+1 and is written at edge N+1.
- **Coalesce visibility:** a coalesced target is visible on lookup and on the write outputs from the cycle after acceptance.
- **Throughput:** one enqueue or coalesce and one pop per cycle.
- **Combinational paths:** `write_enabled` is combinational from `btb_stall` and registered count. `lookup_*` are combinational from `lookup_pc`. All other outputs are registered.

## Structure
- Shared package `branch_pkg`:
  - `ADDRESS_LEN` and default `DEPTH`.
  - typedef `bq_entry_t` {`pc`, `target`}.
  - Pointer-width constant derived from `DEPTH`.
- One sub-module, `bq_entry`: holds the valid bit, PC and target registers; provides `pc == lookup_pc` and `pc == resolve_pc` comparators; supports a write-new strobe, a target-overwrite strobe and an invalidate strobe. The top level instantiates DEPTH copies in a generate loop.
- Top level holds pointers, count, match priority/exclusion logic and output muxes.

## Test plan
- **Reset and not-taken:** hold `reset = 0` for 2 cycles, then release; send not-taken PC 0x0040 → `count = 0`, `write_enabled = 0`, `resolve_ready = 1`, `lookup_hit = 0`.
- **Single drain:** enqueue PC 0x0100 / target 0x0200 with `btb_stall = 0` → next cycle `write_enabled = 1`, outputs 0x0100 / 0x0200; then `count` returns to 0.
- **Full and wrap-around:** hold `btb_stall = 1` and enqueue 4 distinct PCs → `full = 1`, `resolve_ready = 0`. Release the stall → 4 writes in FIFO order on consecutive cycles. Repeat twice to exercise pointer wrap.
- **Coalesce:** with stall high, enqueue PC 0x0300 / target 0x0400, then PC 0x0300 / target 0x0500 → `count = 1`, lookup of 0x0300 returns 0x0500, and the drained write carries 0x0500.
- **Head-pop exclusion:** head is PC 0x0600 / target 0x0700 and is popping; in the same cycle send PC 0x0600 / target 0x0800 → the BTB is written with 0x0700, `count = 1`, and the next write is 0x0600 / 0x0800.
- **Reset mid-operation:** with 3 entries queued, assert reset for 1 cycle → `count = 0`, no `write_enabled` pulse, and `lookup_hit = 0` for all previously queued PCs.
